// File: rtl/nmos_clk_gen.sv
// nmos_clk_gen: two-phase non-overlapping PHI1/PHI2 clock generator for NMOS
// cells. Phase high time and inter-phase gap are programmable and latched at
// the start of every cycle. Supports free-running (run) and single-step
// (step_req) operation and counts completed PHI1/PHI2 cycles.
module nmos_clk_gen #(
    parameter int CNT_W = 4,
    parameter int CYC_W = 16
) (
    input  logic             main_clk,
    input  logic             main_rst,
    input  logic             run,
    input  logic             step_req,
    input  logic [CNT_W-1:0] cfg_hi,
    input  logic [CNT_W-1:0] cfg_gap,
    output logic             phi1,
    output logic             phi2,
    output logic             phi1_rise,
    output logic             step_ack,
    output logic             busy,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_G1,
        S_P2,
        S_G2
    } state_t;

    typedef enum logic {
        CAUSE_RUN,
        CAUSE_STEP
    } cause_t;

    state_t           r_state;
    cause_t           r_cause;
    logic [CNT_W-1:0] r_phaseCnt;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_gap;
    logic [CYC_W-1:0] r_cycCnt;
    logic             r_stepAck;

    logic [CNT_W-1:0] w_hiLen;
    logic [CNT_W-1:0] w_gapLen;
    logic             w_hiLast;
    logic             w_gapLast;

    // A latched length of zero behaves as one so the gap always separates
    // the phases and no phase ever collapses to nothing.
    assign w_hiLen   = (r_hi  == '0) ? CNT_W'(1) : r_hi;
    assign w_gapLen  = (r_gap == '0) ? CNT_W'(1) : r_gap;

    // The phase counter runs 0..len-1 inside each state, so it never exceeds
    // the largest representable length minus one.
    assign w_hiLast  = (r_phaseCnt == (w_hiLen  - CNT_W'(1)));
    assign w_gapLast = (r_phaseCnt == (w_gapLen - CNT_W'(1)));

    // Sequencer: IDLE -> P1 -> G1 -> P2 -> G2 -> (P1 | IDLE), latching config
    // and start cause on each P1 entry and counting cycles at the end of G2.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_state    <= S_IDLE;
            r_cause    <= CAUSE_RUN;
            r_phaseCnt <= '0;
            r_hi       <= '0;
            r_gap      <= '0;
            r_cycCnt   <= '0;
            r_stepAck  <= 1'b0;
        end else begin
            r_stepAck <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_P1;
                        r_cause    <= CAUSE_RUN;
                        r_phaseCnt <= '0;
                        r_hi       <= cfg_hi;
                        r_gap      <= cfg_gap;
                    end else if (step_req) begin
                        r_state    <= S_P1;
                        r_cause    <= CAUSE_STEP;
                        r_phaseCnt <= '0;
                        r_hi       <= cfg_hi;
                        r_gap      <= cfg_gap;
                    end
                end
                S_P1: begin
                    if (w_hiLast) begin
                        r_state    <= S_G1;
                        r_phaseCnt <= '0;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CNT_W'(1);
                    end
                end
                S_G1: begin
                    if (w_gapLast) begin
                        r_state    <= S_P2;
                        r_phaseCnt <= '0;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CNT_W'(1);
                    end
                end
                S_P2: begin
                    if (w_hiLast) begin
                        r_state    <= S_G2;
                        r_phaseCnt <= '0;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CNT_W'(1);
                    end
                end
                S_G2: begin
                    if (w_gapLast) begin
                        r_cycCnt   <= r_cycCnt + CYC_W'(1);
                        r_phaseCnt <= '0;
                        if (run) begin
                            r_state <= S_P1;
                            r_cause <= CAUSE_RUN;
                            r_hi    <= cfg_hi;
                            r_gap   <= cfg_gap;
                        end else begin
                            r_state   <= S_IDLE;
                            r_stepAck <= (r_cause == CAUSE_STEP);
                        end
                    end else begin
                        r_phaseCnt <= r_phaseCnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_phaseCnt <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registered state; inputs never reach them
    // combinationally, and P1/P2 being distinct states rules out overlap.
    assign phi1      = (r_state == S_P1);
    assign phi2      = (r_state == S_P2);
    assign phi1_rise = (r_state == S_P1) && (r_phaseCnt == '0);
    assign busy      = (r_state != S_IDLE);
    assign step_ack  = r_stepAck;
    assign cyc_cnt   = r_cycCnt;

endmodule

// File: tb/tb_nmos_clk_gen.sv
// tb_nmos_clk_gen: directed stimulus for nmos_clk_gen with a cycle-offset
// reference model compared every cycle, plus hand-computed trace literals.
module tb_nmos_clk_gen;

    localparam int CNT_W = 4;
    localparam int CYC_W = 4;

    logic             main_clk = 1'b0;
    logic             main_rst;
    logic             run;
    logic             step_req;
    logic [CNT_W-1:0] cfg_hi;
    logic [CNT_W-1:0] cfg_gap;
    logic             phi1;
    logic             phi2;
    logic             phi1_rise;
    logic             step_ack;
    logic             busy;
    logic [CYC_W-1:0] cyc_cnt;

    int checks   = 0;
    int failures = 0;

    nmos_clk_gen #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .run      (run),
        .step_req (step_req),
        .cfg_hi   (cfg_hi),
        .cfg_gap  (cfg_gap),
        .phi1     (phi1),
        .phi2     (phi2),
        .phi1_rise(phi1_rise),
        .step_ack (step_ack),
        .busy     (busy),
        .cyc_cnt  (cyc_cnt)
    );

    // Free-running simulation clock, 10 time units per period.
    always #5 main_clk = ~main_clk;

    // Reference model: position within the current PHI cycle as a plain offset.
    bit mValid   = 1'b0;
    bit mBusy    = 1'b0;
    bit mStep    = 1'b0;
    bit mAck     = 1'b0;
    int mOff     = 0;
    int mHi      = 1;
    int mGap     = 1;
    int mCyc     = 0;

    function automatic int effLen(input logic [CNT_W-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    // Advance the model on every rising edge using the inputs the DUT samples.
    always @(posedge main_clk) begin
        if (main_rst) begin
            mValid = 1'b1;
            mBusy  = 1'b0;
            mStep  = 1'b0;
            mAck   = 1'b0;
            mOff   = 0;
            mCyc   = 0;
        end else if (mValid) begin
            mAck = 1'b0;
            if (!mBusy) begin
                if (run || step_req) begin
                    mBusy = 1'b1;
                    mOff  = 0;
                    mHi   = effLen(cfg_hi);
                    mGap  = effLen(cfg_gap);
                    mStep = !run;
                end
            end else if (mOff == 2 * (mHi + mGap) - 1) begin
                mCyc = (mCyc + 1) % (1 << CYC_W);
                if (run) begin
                    mOff  = 0;
                    mHi   = effLen(cfg_hi);
                    mGap  = effLen(cfg_gap);
                    mStep = 1'b0;
                end else begin
                    mBusy = 1'b0;
                    mAck  = mStep;
                end
            end else begin
                mOff = mOff + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge main_clk) begin
        if (mValid) begin
            checkOutput("phi1",      64'(phi1),      64'(mBusy && mOff < mHi));
            checkOutput("phi2",      64'(phi2),      64'(mBusy && mOff >= mHi + mGap && mOff < 2 * mHi + mGap));
            checkOutput("phi1_rise", 64'(phi1_rise), 64'(mBusy && mOff == 0));
            checkOutput("busy",      64'(busy),      64'(mBusy));
            checkOutput("step_ack",  64'(step_ack),  64'(mAck));
            checkOutput("cyc_cnt",   64'(cyc_cnt),   64'(mCyc));
            checkOutput("no_overlap", 64'(phi1 & phi2), 64'(0));
        end
    end

    // Trace capture used by the hand-computed literal checks.
    logic [63:0]      p1Bits;
    logic [63:0]      p2Bits;
    logic [63:0]      riseBits;
    logic [63:0]      busyBits;
    logic [63:0]      ackBits;
    int               traceIdx;
    logic             lastPhi1;
    logic             lastBusy;
    logic             lastAck;
    logic [CYC_W-1:0] lastCyc;

    task automatic clearTrace();
        p1Bits   = '0;
        p2Bits   = '0;
        riseBits = '0;
        busyBits = '0;
        ackBits  = '0;
        traceIdx = 0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge main_clk);
            @(negedge main_clk);
            if (traceIdx < 64) begin
                p1Bits[traceIdx]   = phi1;
                p2Bits[traceIdx]   = phi2;
                riseBits[traceIdx] = phi1_rise;
                busyBits[traceIdx] = busy;
                ackBits[traceIdx]  = step_ack;
            end
            lastPhi1 = phi1;
            lastBusy = busy;
            lastAck  = step_ack;
            lastCyc  = cyc_cnt;
            traceIdx++;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rn, input logic st,
                                 input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] gap);
        main_rst = rst;
        run      = rn;
        step_req = st;
        cfg_hi   = hi;
        cfg_gap  = gap;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        // Reset with run high: the cycle after reset stays quiet.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 4'd1);
        capture(1);
        checkOutput("rst_phi1", 64'(lastPhi1), 64'(0));
        checkOutput("rst_busy", 64'(lastBusy), 64'(0));
        checkOutput("rst_cyc",  64'(lastCyc),  64'(0));

        // Free run hi=3 gap=1: period 8.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd1);
        clearTrace();
        capture(16);
        checkOutput("run31_phi1", p1Bits[15:0],   64'h0707);
        checkOutput("run31_phi2", p2Bits[15:0],   64'h7070);
        checkOutput("run31_rise", riseBits[15:0], 64'h0101);
        checkOutput("run31_busy", busyBits[15:0], 64'hFFFF);
        checkOutput("run31_cyc",  64'(lastCyc),   64'd1);

        // Zero config behaves as 1/1: period 4.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        capture(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        clearTrace();
        capture(8);
        checkOutput("zero_phi1", p1Bits[7:0], 64'h11);
        checkOutput("zero_phi2", p2Bits[7:0], 64'h44);
        checkOutput("zero_cyc",  64'(lastCyc), 64'd1);

        // Single step hi=2 gap=2 with a second step request while busy.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        capture(1);
        clearTrace();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
        capture(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        capture(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
        capture(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        capture(9);
        checkOutput("step_phi1", p1Bits[11:0],   64'h003);
        checkOutput("step_phi2", p2Bits[11:0],   64'h030);
        checkOutput("step_busy", busyBits[11:0], 64'h0FF);
        checkOutput("step_ack",  ackBits[11:0],  64'h100);
        checkOutput("step_cyc",  64'(lastCyc),   64'd1);

        // Step coincident with run in IDLE is a plain run start, no ack later.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        clearTrace();
        capture(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        capture(5);
        checkOutput("runstep_ack",  ackBits[5:0],  64'h00);
        checkOutput("runstep_busy", busyBits[5:0], 64'h0F);

        // hi 5 -> 2 mid-cycle, then run dropped in the middle of the second P2.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 4'd1);
        capture(1);
        clearTrace();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 4'd1);
        capture(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 4'd1);
        capture(14);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
        capture(4);
        checkOutput("drop_phi1", p1Bits[19:0],   64'h0301F);
        checkOutput("drop_phi2", p2Bits[19:0],   64'h187C0);
        checkOutput("drop_busy", busyBits[19:0], 64'h3FFFF);
        checkOutput("drop_cyc",  64'(lastCyc),   64'd2);

        // Counter wrap with a 4-bit cycle counter at period 4.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        capture(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        clearTrace();
        capture(64);
        checkOutput("wrap_cyc15", 64'(lastCyc), 64'd15);
        capture(1);
        checkOutput("wrap_cyc0",  64'(lastCyc), 64'd0);

        // Reset asserted in the first cycle of a P1 after one completed cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 4'd1);
        capture(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd1);
        clearTrace();
        capture(9);
        checkOutput("midrst_pre_phi1", 64'(lastPhi1), 64'd1);
        checkOutput("midrst_pre_cyc",  64'(lastCyc),  64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 4'd1);
        capture(1);
        checkOutput("midrst_phi1", 64'(lastPhi1), 64'd0);
        checkOutput("midrst_busy", 64'(lastBusy), 64'd0);
        checkOutput("midrst_cyc",  64'(lastCyc),  64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 4'd1);
        capture(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop so the run always terminates even if stimulus stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/nmos_clk_gen.md
NMOS_CLK_GEN -- requirements
Module: nmos_clk_gen

Interface
REQ-001 Parameter CNT_W, default 4: width of the phase-length and gap configuration inputs.
REQ-002 Parameter CYC_W, default 16: width of the completed-cycle counter.
REQ-003 main_clk  input  1  single simulation clock; all state changes on its rising edge.
REQ-004 main_rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 run  input  1  level; free-running PHI1/PHI2 generation while high.
REQ-006 step_req  input  1  single-cycle pulse; requests exactly one PHI1/PHI2 cycle while stopped.
REQ-007 cfg_hi  input  CNT_W  high time of each phase, in main_clk cycles.
REQ-008 cfg_gap  input  CNT_W  non-overlap gap after each phase, in main_clk cycles.
REQ-009 phi1  output  1  PHI1 clock to NMOS cells (C1).
REQ-010 phi2  output  1  PHI2 clock to NMOS cells (C2).
REQ-011 phi1_rise  output  1  one-cycle pulse in the first main_clk cycle of each PHI1 high phase.
REQ-012 step_ack  output  1  one-cycle pulse when a stepped cycle completes.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 cyc_cnt  output  CYC_W  count of completed PHI1/PHI2 cycles.

Function
REQ-015 The state machine SHALL have five states: IDLE, P1, G1, P2, G2, with all outputs decoded directly from registered state (no combinational input-to-output path).
REQ-016 phi1 SHALL be high exactly in P1 cycles; phi2 exactly in P2 cycles; both low in IDLE, G1, G2; phi1 and phi2 SHALL never be high in the same cycle.
REQ-017 IDLE -> P1 when run=1, or when run=0 and step_req=1; the start cause (run/step) SHALL be latched.
REQ-018 On every entry to P1, cfg_hi and cfg_gap SHALL be latched; changes mid-cycle take effect only at the next P1 entry.
REQ-019 Latched value 0 of cfg_hi or cfg_gap SHALL be treated as 1 (gap minimum 1 guarantees non-overlap).
REQ-020 P1 and P2 SHALL each last hi cycles; G1 and G2 each last gap cycles; sequence P1 -> G1 -> P2 -> G2.
REQ-021 Full period SHALL be 2*(hi+gap) main_clk cycles, with no extra cycle between G2 and the next P1 while running.
REQ-022 At the end of G2: cyc_cnt SHALL increment (wrapping from all-ones to 0); next state P1 if run=1, else IDLE.
REQ-023 Dropping run mid-cycle SHALL NOT truncate the cycle; the current cycle completes through G2, then IDLE.
REQ-024 A stepped cycle SHALL end in IDLE unless run=1 at end of G2, and SHALL pulse step_ack in the first IDLE cycle after that G2.
REQ-025 step_req while busy=1, or coincident with run=1 in IDLE, SHALL be ignored (no queued step, no step_ack).
REQ-026 phi1_rise SHALL be high exactly in the first cycle of each P1.
REQ-027 cyc_cnt SHALL be the only counter visible outside; phase counters SHALL be CNT_W wide and never overflow.

Reset
REQ-028 While main_rst=1, state SHALL go to IDLE, phase counter and latched config to 0, cyc_cnt to 0, latched start cause to run.
REQ-029 During and in the cycle after reset, phi1, phi2, phi1_rise, step_ack, busy SHALL all be 0.
REQ-030 main_rst SHALL take priority over run and step_req in the same cycle; reset mid-phase SHALL force both phases low next cycle.
REQ-031 First P1 SHALL occur no earlier than the cycle after the first edge where main_rst=0 and run=1 are sampled.

Verification
REQ-032 run=1, cfg_hi=3, cfg_gap=1 after reset -> phi1 high 3, low 1, phi2 high 3, low 1; period 8; cyc_cnt +1 every 8 cycles.
REQ-033 cfg_hi=0, cfg_gap=0 -> behaves as 1/1; period 4; phi1 and phi2 never high together.
REQ-034 run=0, one step_req pulse, cfg_hi=2, cfg_gap=2 -> exactly one 8-cycle cycle, step_ack one cycle later, cyc_cnt=1, then IDLE; second step_req during busy ignored.
REQ-035 run dropped in middle of P2 -> P2 and G2 complete, then IDLE; cfg_hi changed 5->2 mid-cycle -> new value only from next P1.
REQ-036 CYC_W=4, run for 16 cycles -> cyc_cnt wraps 15->0; main_rst asserted mid-P1 -> phi1=0, cyc_cnt=0, busy=0 the next cycle.
